// File: rtl/sm4_key_cache_ctrl.sv
// Four-entry fully associative key-tag cache controller for the SM4 encryptor.
// Resolves a 128-bit key to a round-key slot, allocating and filling a victim on a miss.
module sm4_key_cache_ctrl (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         lookup_v_i,
  output logic         lookup_ready_o,
  input  logic [127:0] lookup_key_i,
  output logic         resp_v_o,
  input  logic         resp_ready_i,
  output logic [1:0]   resp_slot_o,
  output logic         resp_hit_o,
  output logic         expand_v_o,
  input  logic         expand_ready_i,
  output logic [127:0] expand_key_o,
  output logic [1:0]   expand_slot_o,
  input  logic         expand_done_i,
  output logic         lru_v_o,
  output logic [1:0]   lru_access_o,
  input  logic [1:0]   lru_replace_i
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_EXP_REQ  = 3'd2,
    S_EXP_WAIT = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [3:0][127:0]   tag_q, tag_d;
  logic [3:0]          valid_q, valid_d;
  logic [127:0]        key_q, key_d;
  logic [1:0]          slot_q, slot_d;
  logic                hit_q, hit_d;
  logic                lru_v_q, lru_v_d;
  logic [3:0]          match_s;
  logic                any_hit_s;
  logic [1:0]          hit_slot_s;
  logic [1:0]          victim_s;

  // Tags are unique, so at most one match bit can be set.
  always_comb begin
    match_s    = 4'b0000;
    hit_slot_s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      match_s[i] = valid_q[i] && (tag_q[i] == key_q);
      if (match_s[i]) begin
        hit_slot_s = 2'(i);
      end else begin
        hit_slot_s = hit_slot_s;
      end
    end
  end

  assign any_hit_s = |match_s;

  // Free slots are consumed lowest-first before the LRU recorder is consulted.
  always_comb begin
    if (!valid_q[0]) begin
      victim_s = 2'd0;
    end else if (!valid_q[1]) begin
      victim_s = 2'd1;
    end else if (!valid_q[2]) begin
      victim_s = 2'd2;
    end else if (!valid_q[3]) begin
      victim_s = 2'd3;
    end else begin
      victim_s = lru_replace_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!flush_i && lookup_v_i) state_d = S_LOOKUP;
        else                        state_d = S_IDLE;
      end
      S_LOOKUP: begin
        if (any_hit_s) state_d = S_RESP;
        else           state_d = S_EXP_REQ;
      end
      S_EXP_REQ: begin
        if (expand_ready_i) state_d = S_EXP_WAIT;
        else                state_d = S_EXP_REQ;
      end
      S_EXP_WAIT: begin
        if (expand_done_i) state_d = S_RESP;
        else               state_d = S_EXP_WAIT;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
        else              state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A victim stays invalid until its fill completes, so it can never false-hit.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    key_d   = key_q;
    slot_d  = slot_q;
    hit_d   = hit_q;
    lru_v_d = (state_d == S_RESP) && (state_q != S_RESP);
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          valid_d = 4'b0000;
        end else if (lookup_v_i) begin
          key_d = lookup_key_i;
        end else begin
          key_d = key_q;
        end
      end
      S_LOOKUP: begin
        if (any_hit_s) begin
          slot_d = hit_slot_s;
          hit_d  = 1'b1;
        end else begin
          slot_d            = victim_s;
          tag_d[victim_s]   = key_q;
          valid_d[victim_s] = 1'b0;
          hit_d             = 1'b0;
        end
      end
      S_EXP_WAIT: begin
        if (expand_done_i) valid_d[slot_q] = 1'b1;
        else               valid_d = valid_q;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q   <= '0;
      valid_q <= 4'b0000;
      key_q   <= 128'd0;
      slot_q  <= 2'd0;
      hit_q   <= 1'b0;
      lru_v_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      slot_q  <= slot_d;
      hit_q   <= hit_d;
      lru_v_q <= lru_v_d;
    end
  end

  // Data outputs are forced to zero whenever their valid is low.
  always_comb begin
    lookup_ready_o = (state_q == S_IDLE) && !flush_i && !reset_i;
    expand_v_o     = (state_q == S_EXP_REQ);
    expand_key_o   = expand_v_o ? key_q : 128'd0;
    expand_slot_o  = expand_v_o ? slot_q : 2'd0;
    resp_v_o       = (state_q == S_RESP);
    resp_slot_o    = resp_v_o ? slot_q : 2'd0;
    resp_hit_o     = resp_v_o ? hit_q : 1'b0;
    lru_v_o        = lru_v_q;
    lru_access_o   = lru_v_q ? slot_q : 2'd0;
  end

endmodule
